// File: rtl/booth_r4_multiplier_if.sv
// Control and data bundle for booth_r4_multiplier: the execute stage drives the
// master side, the multiplier implements the slave side.
interface booth_r4_multiplier_if #(
  parameter int WIDTH = 64
);
  // Handshake: op_start is a request level that is honoured only on an edge
  // where the unit is in IDLE and op_clear is low; it is silently ignored in
  // CALC and DONE. op_done is a one-cycle completion pulse, and result is valid
  // from that pulse until the next accepted start or clear. op_clear aborts on
  // any edge and wins over op_start.
  logic                 op_start;
  logic                 op_clear;
  logic                 signed_mode;
  logic [WIDTH-1:0]     multiplier;
  logic [WIDTH-1:0]     multiplicand;
  logic                 busy;
  logic                 op_done;
  logic [2*WIDTH-1:0]   result;
  logic [1:0]           dbg_state;

  modport master (
    output op_start, op_clear, signed_mode, multiplier, multiplicand,
    input  busy, op_done, result, dbg_state
  );

  modport slave (
    input  op_start, op_clear, signed_mode, multiplier, multiplicand,
    output busy, op_done, result, dbg_state
  );
endinterface

// File: rtl/booth_r4_multiplier.sv
// Iterative radix-4 Booth multiplier: retires two multiplier bits per clock,
// signed or unsigned per operation, with a result register held between ops.
module booth_r4_multiplier #(
  parameter  int WIDTH = 64,
  localparam int ITER  = (WIDTH + 2) / 2
) (
  input logic                  clk,
  input logic                  reset_n,
  booth_r4_multiplier_if.slave bus
);

  localparam int EW = WIDTH + 2;       // extended operand width
  localparam int HW = WIDTH + 3;       // upper accumulator half, holds +/-2M
  localparam int AW = HW + EW + 1;     // upper half, multiplier, implicit bit
  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        acc_q;
  logic [EW-1:0]        mcand_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   result_q;

  logic                 accept;
  logic                 last_step;
  logic [EW-1:0]        ext_a, ext_b;
  logic [HW-1:0]        m_ext, m_dbl, pp_mag, pp_add, hi_sum;
  logic                 pp_neg;
  logic [AW-1:0]        acc_step;

  assign accept    = (state_q == S_IDLE) && bus.op_start && !bus.op_clear;
  assign last_step = (cnt_q == CW'(1));

  assign ext_a = bus.signed_mode ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
                                 : {2'b00, bus.multiplier};
  assign ext_b = bus.signed_mode ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                                 : {2'b00, bus.multiplicand};

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CALC;
      S_CALC:  if (last_step) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.op_clear) state_d = S_IDLE;
  end

  // Booth recoding of the window {b(i+1), b(i), b(i-1)} at the accumulator LSBs
  assign m_ext = {mcand_q[EW-1], mcand_q};
  assign m_dbl = {m_ext[HW-2:0], 1'b0};

  always_comb begin
    pp_mag = '0;
    pp_neg = 1'b0;
    case (acc_q[2:0])
      3'b001, 3'b010: pp_mag = m_ext;
      3'b011:         pp_mag = m_dbl;
      3'b100: begin   pp_mag = m_dbl; pp_neg = 1'b1; end
      3'b101, 3'b110: begin pp_mag = m_ext; pp_neg = 1'b1; end
      default: begin  pp_mag = '0;    pp_neg = 1'b0; end
    endcase
  end

  // Subtraction is the one's complement plus a carry-in of one
  assign pp_add   = pp_neg ? ~pp_mag : pp_mag;
  assign hi_sum   = acc_q[AW-1 -: HW] + pp_add + HW'(pp_neg);
  assign acc_step = AW'($signed({hi_sum, acc_q[EW:0]}) >>> 2);

  // Datapath: operands, accumulator, iteration counter and held result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (bus.op_clear) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      acc_q   <= {{HW{1'b0}}, ext_a, 1'b0};
      mcand_q <= ext_b;
      cnt_q   <= CW'(ITER);
    end else if (state_q == S_CALC) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q - CW'(1);
      // The product sits just above the implicit bit once all steps are done
      if (last_step) result_q <= acc_step[2*WIDTH:1];
    end
  end

  assign bus.busy      = (state_q == S_CALC);
  assign bus.op_done   = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.dbg_state = state_q;

endmodule

// File: doc/booth_r4_multiplier.md
Name: booth_r4_multiplier

Overview:
- Parametrised, iterative radix-4 Booth multiplier; next generation of the team's 64-bit radix-2 sequential multiplier.
- Retires 2 multiplier bits per cycle, roughly halving latency.
- Adds a per-operation signed/unsigned mode, a busy flag and a held result.
- Sits behind the core's execute stage under the same op_start/op_clear/op_done control protocol.

Parameters:
- WIDTH, 64, operand width in bits; must be even and >= 4.
- ITER, (WIDTH+2)/2, derived iteration count; not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  reset; one clock; reset is asynchronous and active-low
- op_start  input  1  request to start; sampled only in IDLE
- op_clear  input  1  synchronous abort/clear; highest priority after reset
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with op_start
- multiplier  input  WIDTH  operand A; sampled with op_start
- multiplicand  input  WIDTH  operand B; sampled with op_start
- busy  output  1  high in CALC
- op_done  output  1  one-cycle pulse, high in DONE
- result  output  2*WIDTH  product; held until next accepted start or clear

Behaviour:
- States: IDLE, CALC, DONE. Encoding is free.
- Reset (async, reset_n=0):
  - state=IDLE, iteration counter=0, operand/accumulator registers=0.
  - Outputs: result=0, busy=0, op_done=0.
  - Applies immediately, including mid-operation.
- op_clear=1 at a clock edge, in any state:
  - Next state=IDLE; result, accumulator and counter cleared to 0.
  - op_start on the same edge is ignored.
- IDLE:
  - op_start=1 and op_clear=0 at edge E accepts the operation.
  - At E, latch multiplier and multiplicand, extended to WIDTH+2 bits (sign-extended if signed_mode=1, zero-extended if 0).
  - At E, load the accumulator with the extended multiplier plus an implicit 0 below the LSB, and set counter=ITER. Next state=CALC.
- CALC, one Booth step per edge:
  - Examine the 3-bit window {b(i+1), b(i), b(i-1)} at the accumulator LSBs.
  - Add 0, +M, +2M, -M or -2M (M = extended multiplicand) to the upper accumulator half. The upper half is WIDTH+3 bits wide so ±2M never overflows.
  - Then arithmetic-shift the whole accumulator right by 2 and decrement the counter.
  - Subtraction is add of the complement with carry-in 1.
  - When the counter reaches 0 after the step, next state=DONE.
  - op_start is ignored while in CALC.
- DONE:
  - Lasts exactly one cycle; op_done=1; then IDLE.
  - result register updates on the edge that enters DONE.
- Latency:
  - Accept edge E. op_done is high in the cycle following edge E+ITER (33 for WIDTH=64, 5 for WIDTH=8).
  - Back-to-back: a new op_start is accepted at the DONE→IDLE edge only if sampled while in IDLE. Minimum start-to-start spacing is ITER+2 cycles.
- Arithmetic:
  - result = exact 2*WIDTH-bit product: two's complement if signed_mode=1, unsigned otherwise.
  - No overflow is possible.
- result is stable in IDLE, CALC and DONE, except for the single update at DONE entry. It never shows intermediate accumulator values.
- busy=1 exactly when state=CALC.

Test Plan:
- WIDTH=64, signed_mode=0, A=B=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001. op_done pulses exactly 33 cycles after the accept edge; busy high for 33 cycles.
- WIDTH=64, signed_mode=1:
  - A=B=-1 -> result=1.
  - A=B=0x8000_0000_0000_0000 -> result=0x4000_0000_0000_0000_0000_0000_0000_0000.
- WIDTH=8 instance:
  - Signed -128*127 -> result=0xC080.
  - Unsigned 0xFF*0xFF -> 0xFE01.
  - Signed 0*0x80 -> 0x0000.
  - op_done 5 cycles after accept.
- Abort and ignored start:
  - op_clear asserted mid-CALC (cycle 10 of 33) -> next cycle IDLE, result=0, busy=0, no op_done.
  - op_start held high during CALC -> no restart; the product is unchanged.
- Reset mid-operation: reset_n low mid-CALC, between clock edges -> busy, op_done and result are 0 immediately. The next op_start after release produces a correct product.
- Back-to-back: op_start held continuously with changing operands -> each product is correct. Start-to-start spacing is ITER+2 cycles, and result holds the prior product until the next DONE.
